regfile_scoreboard: RTL

Parametrised successor to the processor's 16x16 register file. Provides:
- NUM_READ combinational read ports with same-cycle write-to-read bypass.
- An optional hardwired zero register.
- A per-register busy scoreboard for hazard detection in the pipeline.
- A sequenced flush state machine that zeroes the array one entry per cycle.

It sits between the decode/issue stage (reads, reservations) and the writeback stage (writes).

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle: writeback, read, reserve and flush signals.
// Latency: none, pure wiring between issue/writeback logic and the register file.
// Backpressure: none; writes and reservations arriving during a flush sweep are dropped.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 2
);
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           rsv_en;
  logic [ADDR_WIDTH-1:0]          rsv_addr;
  logic                           clear_req;
  logic                           clear_busy;
  logic                           clear_done;
  logic                           wr_committed;

  // Pipeline side: drives requests, observes read data and status.
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clear_req,
    input  rd_data, rd_busy, clear_busy, clear_done, wr_committed
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clear_req,
    output rd_data, rd_busy, clear_busy, clear_done, wr_committed
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write bypass, busy scoreboard and sequenced flush.
// Latency: reads/busy are combinational (0 cycles); writes land at the edge, wr_committed one cycle later.
// Backpressure: none; requests during a DEPTH-cycle flush sweep are silently discarded.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b0
) (
  input logic                 clock,
  input logic                 reset_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Counter is one bit wider than an address so DEPTH is representable.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     sweep_cnt;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic                    idle;
  logic                    wr_acc;
  logic                    rsv_acc;
  logic                    clear_busy_q;
  logic                    clear_done_q;
  logic                    wr_committed_q;
  logic [ADDR_WIDTH-1:0]   ra;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_READ-1:0]     rd_busy_c;

  assign idle       = (state == IDLE);
  assign sweep_addr = sweep_cnt[ADDR_WIDTH-1:0];

  // Register 0 is not a real destination when hardwired to zero.
  assign wr_acc  = bus.wr_en  && idle && !(ZERO_REG && (bus.wr_addr  == '0));
  assign rsv_acc = bus.rsv_en && idle && !(ZERO_REG && (bus.rsv_addr == '0));

  // Flush sequencer with registered status outputs and write-commit flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sweep_cnt      <= '0;
      clear_busy_q   <= 1'b0;
      clear_done_q   <= 1'b0;
      wr_committed_q <= 1'b0;
    end else begin
      clear_done_q   <= 1'b0;
      wr_committed_q <= wr_acc;
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state        <= SWEEP;
            sweep_cnt    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == CNT_LAST) begin
            state        <= IDLE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array: sweep zeroing takes priority, otherwise accepted writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!idle) begin
      mem[sweep_addr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard: a reservation is applied after the writeback clear so a new producer stays outstanding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (!idle) begin
      busy[sweep_addr] <= 1'b0;
    end else begin
      if (wr_acc) begin
        busy[bus.wr_addr] <= 1'b0;
      end
      if (rsv_acc) begin
        busy[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  // Read ports with same-cycle writeback bypass of both data and busy-clear.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (ZERO_REG && (ra == '0)) begin
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy_c[i]                          = 1'b0;
      end else if (wr_acc && (bus.wr_addr == ra)) begin
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
        rd_busy_c[i]                          = 1'b0;
      end else begin
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
        rd_busy_c[i]                          = busy[ra];
      end
    end
  end

  assign bus.rd_data      = rd_data_c;
  assign bus.rd_busy      = rd_busy_c;
  assign bus.clear_busy   = clear_busy_q;
  assign bus.clear_done   = clear_done_q;
  assign bus.wr_committed = wr_committed_q;
endmodule
